pwm_multichannel: RTL and testbench

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

---
 rtl/pwm_multichannel.sv | 187 ++++++++++++++++++
 tb/tb_pwm_multichannel.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NCH-channel PWM generator with a shared prescaler, shared
// period counter and double-buffered period/duty registers.
// Compile-time option: define PWM_CENTER_ALIGN_EN for triangle (centre-aligned)
// counting; otherwise the counter is edge-aligned (sawtooth).
// Shadow values move to the active set only at a period boundary, or on the
// next clock while the block is disabled.
module pwm_multichannel #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PSW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [PSW-1:0]       prescale,
    input  logic [WIDTH-1:0]     period,
    input  logic [NCH*WIDTH-1:0] duty,
    input  logic                 load,
    output logic                 pending,
    output logic                 period_start,
    output logic [NCH-1:0]       pwm_out
);

    localparam int unsigned DW = NCH * WIDTH;

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    dir_e dir_q, dir_d;
`endif

    logic [PSW-1:0]   psc_q, psc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [DW-1:0]    duty_sh_q, duty_sh_d;
    logic [DW-1:0]    duty_act_q, duty_act_d;
    logic             pending_q, pending_d;
    logic             period_start_q, period_start_d;
    logic [NCH-1:0]   pwm_q, pwm_d;

    logic tick_c;
    logic boundary_c;
    logic xfer_c;

    // Prescaler: one tick every prescale+1 clocks; >= guards a live shrink of prescale
    always_comb begin
        psc_d  = psc_q;
        tick_c = 1'b0;
        if (!enable) begin
            psc_d = '0;
        end else if (psc_q >= prescale) begin
            psc_d  = '0;
            tick_c = 1'b1;
        end else begin
            psc_d = psc_q + PSW'(1);
        end
    end

    // Main counter and boundary detection; the first tick after enable is itself a boundary
    always_comb begin
        cnt_d      = cnt_q;
        first_d    = first_q;
        boundary_c = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d      = dir_q;
`endif
        if (!enable) begin
            cnt_d   = '0;
            first_d = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d   = DIR_UP;
`endif
        end else if (tick_c) begin
            first_d = 1'b0;
            if (first_q) begin
                cnt_d      = '0;
                boundary_c = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
                dir_d      = DIR_UP;
`endif
            end else begin
`ifdef PWM_CENTER_ALIGN_EN
                // Triangle: 0 up to period_act, back down; reaching 0 is the boundary
                if (dir_q == DIR_UP) begin
                    if (cnt_q < period_act_q) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else if (cnt_q <= WIDTH'(1)) begin
                        cnt_d      = '0;
                        boundary_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                        dir_d = DIR_DN;
                    end
                end else begin
                    if (cnt_q <= WIDTH'(1)) begin
                        cnt_d      = '0;
                        dir_d      = DIR_UP;
                        boundary_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
`else
                // Sawtooth: wrap period_act -> 0; >= keeps the count bounded
                if (cnt_q >= period_act_q) begin
                    cnt_d      = '0;
                    boundary_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
`endif
            end
        end
    end

    // Shadow capture and shadow-to-active transfer; a coincident load re-arms pending
    always_comb begin
        period_sh_d  = period_sh_q;
        duty_sh_d    = duty_sh_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        pending_d    = pending_q;
        xfer_c       = pending_q && (boundary_c || !enable);
        if (xfer_c) begin
            period_act_d = period_sh_q;
            duty_act_d   = duty_sh_q;
            pending_d    = 1'b0;
        end
        if (load) begin
            period_sh_d = period;
            duty_sh_d   = duty;
            pending_d   = 1'b1;
        end
    end

    // Output compare and period_start pulse, both registered
    always_comb begin
        period_start_d = boundary_c;
        pwm_d          = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            pwm_d[i] = enable && (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
        end
    end

    // State register; reset wins over load and enable
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q          <= '0;
            cnt_q          <= '0;
            first_q        <= 1'b1;
            period_sh_q    <= '0;
            duty_sh_q      <= '0;
            period_act_q   <= '0;
            duty_act_q     <= '0;
            pending_q      <= 1'b0;
            period_start_q <= 1'b0;
            pwm_q          <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q          <= DIR_UP;
`endif
        end else begin
            psc_q          <= psc_d;
            cnt_q          <= cnt_d;
            first_q        <= first_d;
            period_sh_q    <= period_sh_d;
            duty_sh_q      <= duty_sh_d;
            period_act_q   <= period_act_d;
            duty_act_q     <= duty_act_d;
            pending_q      <= pending_d;
            period_start_q <= period_start_d;
            pwm_q          <= pwm_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q          <= dir_d;
`endif
        end
    end

    assign pending      = pending_q;
    assign period_start = period_start_q;
    assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel (NCH=4, WIDTH=8, PSW=8).
// Expected {pending, period_start, pwm_out} per clock is queued ahead of each
// window and popped as the DUT produces it. Centre-aligned checks build only
// when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multichannel;

    localparam int unsigned NCH   = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned PSW   = 8;

    typedef struct packed {
        logic           pend;
        logic           ps;
        logic [NCH-1:0] pwm;
    } obs_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [PSW-1:0]       prescale;
    logic [WIDTH-1:0]     period;
    logic [NCH*WIDTH-1:0] duty;
    logic                 load;
    logic                 pending;
    logic                 period_start;
    logic [NCH-1:0]       pwm_out;

    int   n_chk  = 0;
    int   n_fail = 0;
    obs_t sb_q[$];

    pwm_multichannel #(.NCH(NCH), .WIDTH(WIDTH), .PSW(PSW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .prescale     (prescale),
        .period       (period),
        .duty         (duty),
        .load         (load),
        .pending      (pending),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic pend, input logic ps, input logic [NCH-1:0] pwm);
        obs_t o;
        o.pend = pend;
        o.ps   = ps;
        o.pwm  = pwm;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        obs_t got;
        obs_t exp;
        got = mk(pending, period_start, pwm_out);
        n_chk++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %b expected <empty scoreboard>", tag, got);
        end else begin
            exp = sb_q.pop_front();
            assert (got === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b (pend,ps,pwm)", tag, got, exp);
            end
        end
    endtask

    // Advance until period_start, bounded; a timeout shows up as a failed check
    task automatic wait_ps(input string tag);
        for (int i = 0; i < 200; i++) begin
            step();
            if (period_start === 1'b1) break;
        end
        chk_v(tag, 8'(period_start), 8'd1);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        prescale = '0;
        period   = '0;
        duty     = '0;
        step();
        step();
        sb_q.push_back(mk(1'b0, 1'b0, 4'b0000));
        pop_chk("reset_state");

`ifndef PWM_CENTER_ALIGN_EN
        // Load while disabled: pending for one clock, then transferred
        rst    = 1'b0;
        period = 8'd9;
        duty   = {8'd0, 8'd0, 8'd0, 8'd4};
        load   = 1'b1;
        step();
        load = 1'b0;
        sb_q.push_back(mk(1'b1, 1'b0, 4'b0000));
        pop_chk("dis_load");
        step();
        sb_q.push_back(mk(1'b0, 1'b0, 4'b0000));
        pop_chk("dis_xfer");

        // Enable rise: boundary on the first tick, then every 10 clocks
        enable = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            logic b;
            b = (j == 0) ? 1'b1 : (((j - 1) % 10) < 4);
            sb_q.push_back(mk(1'b0, (j % 10) == 0, {3'b000, b}));
        end
        for (int j = 0; j <= 20; j++) begin
            step();
            pop_chk("en_start");
        end

        // Four duties incl. 0 and > period, prescale 0
        period = 8'd9;
        duty   = {8'd10, 8'd9, 8'd3, 8'd0};
        load   = 1'b1;
        step();
        load = 1'b0;
        chk_v("p9_pending_set", 8'(pending), 8'd1);
        wait_ps("p9_boundary");
        chk_v("p9_pending_clr", 8'(pending), 8'd0);
        for (int j = 1; j <= 30; j++) begin
            int c;
            c = (j - 1) % 10;
            sb_q.push_back(mk(1'b0, (j % 10) == 0, {1'b1, c < 9, c < 3, 1'b0}));
        end
        for (int j = 1; j <= 30; j++) begin
            step();
            pop_chk("p9_duties");
        end

        // Prescale 3, period 4: 20-clock period, ch0 high 8 clocks
        prescale = 8'd3;
        period   = 8'd4;
        duty     = {8'd0, 8'd0, 8'd0, 8'd2};
        load     = 1'b1;
        step();
        load = 1'b0;
        chk_v("psc_pending_set", 8'(pending), 8'd1);
        wait_ps("psc_boundary");
        chk_v("psc_pending_clr", 8'(pending), 8'd0);
        for (int j = 1; j <= 40; j++) begin
            int c;
            c = ((j - 1) / 4) % 5;
            sb_q.push_back(mk(1'b0, (j % 20) == 0, {3'b000, c < 2}));
        end
        for (int j = 1; j <= 40; j++) begin
            step();
            pop_chk("psc_window");
        end

        // Mid-period load at counter 2: old duty holds until the boundary
        prescale = 8'd0;
        period   = 8'd9;
        duty     = {8'd0, 8'd0, 8'd0, 8'd3};
        load     = 1'b1;
        step();
        load = 1'b0;
        wait_ps("mid_sync");
        chk_v("mid_sync_pending", 8'(pending), 8'd0);
        duty = {8'd0, 8'd0, 8'd0, 8'd7};
        for (int j = 1; j <= 20; j++) begin
            int d;
            d = (j <= 10) ? 3 : 7;
            sb_q.push_back(mk((j >= 3) && (j < 10), (j % 10) == 0,
                              {3'b000, ((j - 1) % 10) < d}));
        end
        for (int j = 1; j <= 20; j++) begin
            step();
            pop_chk("mid_load");
            load = (j == 2);
        end
        load = 1'b0;

        // Load on the boundary clock: previous shadow goes active, pending stays
        for (int j = 1; j <= 30; j++) begin
            int d;
            d = (j <= 10) ? 7 : ((j <= 20) ? 5 : 1);
            sb_q.push_back(mk((j >= 3) && (j < 20), (j % 10) == 0,
                              {3'b000, ((j - 1) % 10) < d}));
        end
        for (int j = 1; j <= 30; j++) begin
            step();
            pop_chk("bnd_load");
            if (j == 2) begin
                duty = {8'd0, 8'd0, 8'd0, 8'd5};
                load = 1'b1;
            end else if (j == 9) begin
                duty = {8'd0, 8'd0, 8'd0, 8'd1};
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
`else
        // Centre-aligned: period 5 -> 10-clock triangle, ch0 high while count < 2
        rst      = 1'b0;
        prescale = 8'd0;
        period   = 8'd5;
        duty     = {8'd0, 8'd0, 8'd0, 8'd2};
        load     = 1'b1;
        step();
        load = 1'b0;
        step();
        chk_v("ca_xfer", 8'(pending), 8'd0);
        enable = 1'b1;
        for (int j = 0; j <= 30; j++) begin
            int m;
            int t;
            m = (j == 0) ? 0 : ((j - 1) % 10);
            t = (m <= 5) ? m : (10 - m);
            sb_q.push_back(mk(1'b0, (j % 10) == 0, {3'b000, t < 2}));
        end
        for (int j = 0; j <= 30; j++) begin
            step();
            pop_chk("ca_window");
        end
`endif

        // Reset mid-period with load asserted: load discarded, all cleared
        step();
        step();
        step();
        rst    = 1'b1;
        load   = 1'b1;
        period = 8'd9;
        duty   = {8'd9, 8'd9, 8'd9, 8'd9};
        step();
        sb_q.push_back(mk(1'b0, 1'b0, 4'b0000));
        pop_chk("rst_load");
        rst  = 1'b0;
        load = 1'b0;
        // Active period 0 after reset: every tick is a boundary, duties stay 0
        for (int j = 1; j <= 5; j++) sb_q.push_back(mk(1'b0, 1'b1, 4'b0000));
        for (int j = 1; j <= 5; j++) begin
            step();
            pop_chk("post_rst");
        end

        // Disable: period_start suppressed, outputs low
        enable = 1'b0;
        step();
        sb_q.push_back(mk(1'b0, 1'b0, 4'b0000));
        pop_chk("disable");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
